fp_pack: RTL

- Inverse of the single-precision unpack path: takes an unpacked float (sign, wide biased exponent, extended significand with guard/round/sticky) and produces a normalized, rounded IEEE-754 binary32 word.
- Sits at the back end of every FP arithmetic unit (add/mul/div) before writeback.
- Multi-cycle iterative normalizer with valid/ready handshakes on both sides.

---
 rtl/fp_pack.sv | 137 +++++++++++++
 1 files changed

// File: rtl/fp_pack.sv
// fp_pack: iterative normalizer/rounder packing an unpacked float into IEEE-754 binary32.
// Optional build macro FP_PACK_FLAGS_EN enables the overflow/underflow/inexact flags;
// without it the flag ports are tied to 0 and out_bits is unchanged.
module fp_pack #(
   parameter int MANT_W = 27,
   parameter int EXP_W  = 10
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic              in_sign_i,
   input  logic [EXP_W-1:0]  in_exp_i,
   input  logic [MANT_W-1:0] in_mant_i,
   input  logic              in_sticky_i,
   input  logic              in_nan_i,
   input  logic              in_inf_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [31:0]       out_bits_o,
   output logic              out_overflow_o,
   output logic              out_underflow_o,
   output logic              out_inexact_o
);
   localparam int XW = EXP_W + 1;
   localparam logic [1:0] IDLE = 2'd0, NORM = 2'd1, ROUND = 2'd2, DONE = 2'd3;
   localparam logic [MANT_W-1:0] REST_MASK = (MANT_W'(1) << (MANT_W - 26)) - MANT_W'(1);
   localparam logic signed [XW-1:0] ONE = XW'(1);

   logic [1:0]              state_q, state_d;
   logic                    rdy_q, rdy_d;
   logic                    sign_q, sign_d;
   logic signed [XW-1:0]    exp_q, exp_d;
   logic [MANT_W-1:0]       mant_q, mant_d;
   logic                    sticky_q, sticky_d;
   logic [31:0]             bits_q, bits_d;
   logic                    capture, special, shr, grd, rest, inc, ovf;
   logic [24:0]             sum;
   logic [XW-1:0]           enc;

   assign capture = state_q == IDLE && rdy_q && in_valid_i;
   assign special = in_nan_i | in_inf_i | (in_mant_i == '0);
   assign shr     = mant_q[MANT_W-1] | (exp_q < ONE);
   assign grd     = mant_q[MANT_W-26];
   assign rest    = |(mant_q & REST_MASK) | sticky_q;
   assign inc     = grd & (mant_q[MANT_W-25] | rest);
   assign sum     = {1'b0, mant_q[MANT_W-2:MANT_W-25]} + {24'b0, inc};
   assign enc     = sum[24] ? exp_q + ONE : (sum[23] ? exp_q : '0);
   assign ovf     = enc >= XW'(255);

   assign in_ready_o  = rdy_q;
   assign out_valid_o = state_q == DONE;
   assign out_bits_o  = bits_q;

   // Next-state: capture, one normalize step per cycle, round, then hold until accepted
   always_comb begin
      state_d  = state_q;
      sign_d   = sign_q;
      exp_d    = exp_q;
      mant_d   = mant_q;
      sticky_d = sticky_q;
      bits_d   = bits_q;
      if (capture) begin
         sign_d   = in_sign_i;
         exp_d    = {in_exp_i[EXP_W-1], in_exp_i};
         mant_d   = in_mant_i;
         sticky_d = in_sticky_i;
         state_d  = special ? DONE : NORM;
         if (special)
            bits_d = in_nan_i ? 32'h7FC0_0000 : (in_inf_i ? {in_sign_i, 8'hFF, 23'h0} : {in_sign_i, 31'h0});
      end else if (state_q == NORM) begin
         if (shr) begin
            mant_d   = mant_q >> 1;
            exp_d    = exp_q + ONE;
            sticky_d = sticky_q | mant_q[0];
         end else if (!mant_q[MANT_W-2] && exp_q > ONE) begin
            mant_d = mant_q << 1;
            exp_d  = exp_q - ONE;
         end else begin
            state_d = ROUND;
         end
      end else if (state_q == ROUND) begin
         bits_d  = ovf ? {sign_q, 8'hFF, 23'h0} : {sign_q, enc[7:0], sum[22:0]};
         state_d = DONE;
      end else if (state_q == DONE && out_ready_i) begin
         state_d = IDLE;
      end
      rdy_d = state_d == IDLE;
   end

   // State and datapath registers; reset aborts any operation in flight
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= IDLE;
         rdy_q    <= 1'b0;
         sign_q   <= 1'b0;
         exp_q    <= '0;
         mant_q   <= '0;
         sticky_q <= 1'b0;
         bits_q   <= '0;
      end else begin
         state_q  <= state_d;
         rdy_q    <= rdy_d;
         sign_q   <= sign_d;
         exp_q    <= exp_d;
         mant_q   <= mant_d;
         sticky_q <= sticky_d;
         bits_q   <= bits_d;
      end
   end

`ifdef FP_PACK_FLAGS_EN
   logic       inx;
   logic [2:0] flags_q, flags_d;

   assign inx = grd | rest;

   // Flags {overflow, underflow, inexact}: set in ROUND, cleared for specials
   always_comb begin
      flags_d = flags_q;
      if (state_q == ROUND)
         flags_d = {ovf, ~ovf & (enc == '0) & inx, inx | ovf};
      else if (capture)
         flags_d = 3'b000;
   end

   // Flag register held alongside out_bits
   always_ff @(posedge clk_i) begin
      if (reset_i) flags_q <= 3'b000;
      else         flags_q <= flags_d;
   end

   assign {out_overflow_o, out_underflow_o, out_inexact_o} = flags_q;
`else
   assign {out_overflow_o, out_underflow_o, out_inexact_o} = 3'b000;
`endif
endmodule
